ahb_lite_mgr_arbiter: RTL and testbench

Shares one AHB-Lite subordinate (the ahb_lite block) between NUM_MGR managers.
- Round-robin arbitration.
- Ownership changes only at idle boundaries.
- Muxes address-phase and data-phase signals to the subordinate.
- Routes HREADY/HRESP back to the managers.
- Sits between the manager agents and ahb_lite in the subsystem.

---
 rtl/ahb_lite_mgr_arbiter.sv | 121 ++++++++++++
 tb/tb_ahb_lite_mgr_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_mgr_arbiter.sv
// Shares one AHB-Lite subordinate among NUM_MGR managers with round-robin arbitration.
// Ownership moves only when the current owner presents an IDLE, unlocked address phase.
module ahb_lite_mgr_arbiter #(
  parameter int NUM_MGR = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  input  logic [NUM_MGR*ADDR_W-1:0]   M_HADDR,
  input  logic [NUM_MGR*2-1:0]        M_HTRANS,
  input  logic [NUM_MGR-1:0]          M_HWRITE,
  input  logic [NUM_MGR*3-1:0]        M_HSIZE,
  input  logic [NUM_MGR*3-1:0]        M_HBURST,
  input  logic [NUM_MGR-1:0]          M_HMASTLOCK,
  input  logic [NUM_MGR*DATA_W-1:0]   M_HWDATA,
  output logic [DATA_W-1:0]           M_HRDATA,
  output logic [NUM_MGR-1:0]          M_HREADY,
  output logic [NUM_MGR*2-1:0]        M_HRESP,
  output logic                        S_HSEL,
  output logic [ADDR_W-1:0]           S_HADDR,
  output logic [1:0]                  S_HTRANS,
  output logic                        S_HWRITE,
  output logic [2:0]                  S_HSIZE,
  output logic [2:0]                  S_HBURST,
  output logic                        S_HMASTLOCK,
  output logic [DATA_W-1:0]           S_HWDATA,
  output logic                        S_HREADY,
  input  logic [DATA_W-1:0]           S_HRDATA,
  input  logic                        S_HREADYOUT,
  input  logic [1:0]                  S_HRESP,
  output logic [$clog2(NUM_MGR)-1:0]  HMASTER
);

  localparam int MW = $clog2(NUM_MGR);
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  logic [MW-1:0]      owner;
  logic [MW-1:0]      d_owner;
  logic [MW-1:0]      winner;
  logic               d_valid;
  logic [NUM_MGR-1:0] req;
  logic [1:0]         own_trans;
  logic               own_lock;
  logic               arb_en;
  logic               found;
  int                 idx;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_MGR; i++) begin
      req[i] = (M_HTRANS[i*2 +: 2] == TR_NONSEQ);
    end
  end

  always_comb begin
    own_trans   = M_HTRANS[int'(owner)*2 +: 2];
    own_lock    = M_HMASTLOCK[owner];
    S_HADDR     = M_HADDR[int'(owner)*ADDR_W +: ADDR_W];
    S_HTRANS    = HRESET ? TR_IDLE : own_trans;
    S_HWRITE    = M_HWRITE[owner];
    S_HSIZE     = M_HSIZE[int'(owner)*3 +: 3];
    S_HBURST    = M_HBURST[int'(owner)*3 +: 3];
    S_HMASTLOCK = own_lock;
  end

  // search starts just after the owner and ends on the owner itself
  always_comb begin
    winner = owner;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_MGR; k++) begin
      idx = (int'(owner) + k) % NUM_MGR;
      if (!found && req[idx]) begin
        winner = MW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign arb_en = (own_trans == TR_IDLE) && !own_lock;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      owner   <= '0;
      d_valid <= 1'b0;
      d_owner <= '0;
    end else if (S_HREADYOUT) begin
      d_valid <= (S_HTRANS != TR_IDLE);
      d_owner <= owner;
      if (arb_en) owner <= winner;
    end
  end

  assign S_HSEL   = (S_HTRANS != TR_IDLE);
  assign S_HREADY = S_HREADYOUT;
  assign S_HWDATA = M_HWDATA[int'(d_owner)*DATA_W +: DATA_W];
  assign M_HRDATA = S_HRDATA;
  assign HMASTER  = HRESET ? '0 : owner;

  // a non-owner with a pending transfer is stalled and must hold its address
  always_comb begin
    M_HREADY = '1;
    M_HRESP  = '0;
    if (!HRESET) begin
      for (int i = 0; i < NUM_MGR; i++) begin
        if (i == int'(owner))
          M_HREADY[i] = S_HREADYOUT;
        else if (M_HTRANS[i*2 +: 2] != TR_IDLE)
          M_HREADY[i] = 1'b0;
        if (d_valid && (i == int'(d_owner)))
          M_HRESP[i*2 +: 2] = S_HRESP;
      end
    end
  end

  a_data_owner_stable: assert property (@(posedge HCLK) disable iff (HRESET)
    d_valid |-> (d_owner == owner));

endmodule

// File: tb/tb_ahb_lite_mgr_arbiter.sv
// Scoreboard bench for ahb_lite_mgr_arbiter: directed scenarios then randomized traffic,
// expected outputs predicted from an ownership/data-phase model of the arbitration rules.
module tb_ahb_lite_mgr_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = $clog2(N);
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  logic               HCLK = 1'b0;
  logic               HRESET = 1'b1;
  logic [N*AW-1:0]    M_HADDR;
  logic [N*2-1:0]     M_HTRANS;
  logic [N-1:0]       M_HWRITE;
  logic [N*3-1:0]     M_HSIZE;
  logic [N*3-1:0]     M_HBURST;
  logic [N-1:0]       M_HMASTLOCK;
  logic [N*DW-1:0]    M_HWDATA;
  logic [DW-1:0]      M_HRDATA;
  logic [N-1:0]       M_HREADY;
  logic [N*2-1:0]     M_HRESP;
  logic               S_HSEL;
  logic [AW-1:0]      S_HADDR;
  logic [1:0]         S_HTRANS;
  logic               S_HWRITE;
  logic [2:0]         S_HSIZE;
  logic [2:0]         S_HBURST;
  logic               S_HMASTLOCK;
  logic [DW-1:0]      S_HWDATA;
  logic               S_HREADY;
  logic [DW-1:0]      S_HRDATA;
  logic               S_HREADYOUT;
  logic [1:0]         S_HRESP;
  logic [MW-1:0]      HMASTER;

  ahb_lite_mgr_arbiter #(.NUM_MGR(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
    .M_HBURST(M_HBURST), .M_HMASTLOCK(M_HMASTLOCK), .M_HWDATA(M_HWDATA),
    .M_HRDATA(M_HRDATA), .M_HREADY(M_HREADY), .M_HRESP(M_HRESP),
    .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
    .S_HSIZE(S_HSIZE), .S_HBURST(S_HBURST), .S_HMASTLOCK(S_HMASTLOCK),
    .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA),
    .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .HMASTER(HMASTER)
  );

  always #5 HCLK = ~HCLK;

  // manager and subordinate stimulus state
  logic [1:0]    trans [N];
  logic [AW-1:0] addr  [N];
  logic          wr    [N];
  logic [2:0]    sz    [N];
  logic [2:0]    burst [N];
  logic          lock  [N];
  logic [DW-1:0] wdata [N];
  int            rem   [N];
  int            lhold [N];
  logic          s_ready;
  logic [1:0]    s_resp;
  logic [DW-1:0] s_rdata;
  bit            rnd_mode = 0;

  // reference model: address-phase owner and the accepted data phase
  int m_owner = 0;
  int m_dow   = 0;
  bit m_dv    = 0;

  typedef struct {
    logic          sel;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic          hlock;
    logic [DW-1:0] hwdata;
    logic          hready;
    logic [DW-1:0] rdata;
    logic [N-1:0]  mready;
    logic [N*2-1:0] mresp;
    logic [MW-1:0] hmaster;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      M_HADDR[i*AW +: AW]  = addr[i];
      M_HTRANS[i*2 +: 2]   = trans[i];
      M_HWRITE[i]          = wr[i];
      M_HSIZE[i*3 +: 3]    = sz[i];
      M_HBURST[i*3 +: 3]   = burst[i];
      M_HMASTLOCK[i]       = lock[i];
      M_HWDATA[i*DW +: DW] = wdata[i];
    end
    S_HREADYOUT = s_ready;
    S_HRESP     = s_resp;
    S_HRDATA    = s_rdata;
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.haddr   = addr[m_owner];
    e.htrans  = HRESET ? IDLE : trans[m_owner];
    e.sel     = (e.htrans != IDLE);
    e.hwrite  = wr[m_owner];
    e.hsize   = sz[m_owner];
    e.hburst  = burst[m_owner];
    e.hlock   = lock[m_owner];
    e.hwdata  = wdata[m_dow];
    e.hready  = s_ready;
    e.rdata   = s_rdata;
    e.hmaster = HRESET ? '0 : MW'(m_owner);
    e.mready  = '1;
    e.mresp   = '0;
    for (int i = 0; i < N; i++) begin
      if (!HRESET) begin
        if (i == m_owner) e.mready[i] = s_ready;
        else e.mready[i] = (trans[i] == IDLE);
        if (m_dv && i == m_dow) e.mresp[i*2 +: 2] = s_resp;
      end
    end
    return e;
  endfunction

  task automatic model_update();
    int nxt;
    bit found;
    if (HRESET) begin
      m_owner = 0; m_dv = 0; m_dow = 0;
    end else if (s_ready) begin
      nxt = m_owner;
      found = 0;
      if (trans[m_owner] == IDLE && !lock[m_owner]) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_owner + k) % N;
          if (!found && trans[c] == NONSEQ) begin
            nxt = c;
            found = 1;
          end
        end
      end
      m_dv    = (trans[m_owner] != IDLE);
      m_dow   = m_owner;
      m_owner = nxt;
    end
  endtask

  // managers advance on the model's HREADY so a faulty DUT cannot steer the stimulus
  task automatic mgr_advance(input logic [N-1:0] rdy, input bit was_rst);
    for (int i = 0; i < N; i++) begin
      wdata[i] = $urandom;
      if (was_rst) begin
        trans[i] = IDLE; rem[i] = 0; lock[i] = 0; lhold[i] = 0;
      end else if (trans[i] != IDLE) begin
        if (rdy[i]) begin
          if (trans[i] == BUSY) trans[i] = SEQ;
          else begin
            rem[i]--;
            if (rem[i] == 0) trans[i] = IDLE;
            else begin
              addr[i] += 4;
              trans[i] = ($urandom_range(0, 7) == 0) ? BUSY : SEQ;
            end
          end
        end
      end else begin
        if (lhold[i] > 0) lhold[i]--;
        else lock[i] = 0;
        if ($urandom_range(0, 3) == 0) begin
          trans[i] = NONSEQ;
          addr[i]  = $urandom;
          wr[i]    = 1'($urandom_range(0, 1));
          sz[i]    = 3'($urandom_range(0, 2));
          if ($urandom_range(0, 1) == 0) begin burst[i] = 3'd0; rem[i] = 1; end
          else begin burst[i] = 3'd3; rem[i] = 4; end
          lock[i]  = ($urandom_range(0, 5) == 0);
          lhold[i] = $urandom_range(0, 3);
        end
      end
    end
    s_ready = ($urandom_range(0, 4) != 0);
    s_resp  = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
    s_rdata = $urandom;
  endtask

  task automatic step();
    exp_t e;
    bit was_rst;
    apply();
    e = predict();
    q.push_back(e);
    @(posedge HCLK);
    model_update();
    #1;
    was_rst = HRESET;
    if (rnd_mode) begin
      mgr_advance(e.mready, was_rst);
      HRESET = ($urandom_range(0, 299) == 0);
    end
  endtask

  task automatic set_mgr(input int i, input logic [1:0] t, input logic [AW-1:0] a,
                         input logic w, input logic [2:0] b, input logic l,
                         input logic [DW-1:0] d);
    trans[i] = t; addr[i] = a; wr[i] = w; burst[i] = b; lock[i] = l; wdata[i] = d;
  endtask

  // monitor: compares every presented cycle against the next queued prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("s_hsel",     64'(S_HSEL),      64'(e.sel));
        chk("s_haddr",    64'(S_HADDR),     64'(e.haddr));
        chk("s_htrans",   64'(S_HTRANS),    64'(e.htrans));
        chk("s_hwrite",   64'(S_HWRITE),    64'(e.hwrite));
        chk("s_hsize",    64'(S_HSIZE),     64'(e.hsize));
        chk("s_hburst",   64'(S_HBURST),    64'(e.hburst));
        chk("s_hmastlock",64'(S_HMASTLOCK), 64'(e.hlock));
        chk("s_hwdata",   64'(S_HWDATA),    64'(e.hwdata));
        chk("s_hready",   64'(S_HREADY),    64'(e.hready));
        chk("m_hrdata",   64'(M_HRDATA),    64'(e.rdata));
        chk("m_hready",   64'(M_HREADY),    64'(e.mready));
        chk("m_hresp",    64'(M_HRESP),     64'(e.mresp));
        chk("hmaster",    64'(HMASTER),     64'(e.hmaster));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      set_mgr(i, IDLE, '0, 1'b0, 3'd0, 1'b0, '0);
      sz[i] = 3'd2; rem[i] = 0; lhold[i] = 0;
    end
    s_ready = 1'b1; s_resp = 2'b00; s_rdata = '0;
    @(posedge HCLK);
    #1;

    // reset held with M0 requesting, then forwarded on release
    set_mgr(0, NONSEQ, 32'd2, 1'b1, 3'd0, 1'b0, 32'd5);
    step(); step();
    HRESET = 1'b0;
    step();
    set_mgr(0, IDLE, 32'd0, 1'b0, 3'd0, 1'b0, 32'd5);
    step();

    // contention: owner M0 keeps the bus, M1 takes over after M0 idles
    set_mgr(0, NONSEQ, 32'h10, 1'b1, 3'd0, 1'b0, 32'h11);
    set_mgr(1, NONSEQ, 32'h20, 1'b0, 3'd0, 1'b0, 32'h22);
    step();
    trans[0] = IDLE;
    step(); step();
    trans[1] = IDLE;
    step();

    // M1 INCR4 burst holds the bus while M0 waits
    set_mgr(1, NONSEQ, 32'd5, 1'b1, 3'd3, 1'b0, 32'h33);
    set_mgr(0, NONSEQ, 32'h30, 1'b1, 3'd0, 1'b0, 32'h44);
    step();
    for (int b = 1; b < 4; b++) begin
      trans[1] = SEQ; addr[1] = 32'd5 + 32'(4 * b); wdata[1] = 32'(b);
      step();
    end
    trans[1] = IDLE;
    step(); step();
    trans[0] = IDLE;
    step();

    // wait states: owner holds through the stall even when idle
    set_mgr(0, NONSEQ, 32'h40, 1'b0, 3'd0, 1'b0, 32'h0);
    step();
    trans[0] = IDLE;
    set_mgr(1, NONSEQ, 32'h50, 1'b0, 3'd0, 1'b0, 32'h0);
    s_ready = 1'b0; s_rdata = 32'hAB;
    step(); step();
    s_ready = 1'b1; s_rdata = 32'hCD;
    step(); step();
    trans[1] = IDLE;
    step();

    // lock: idle but locked owner is not pre-empted
    lock[1] = 1'b1;
    set_mgr(0, NONSEQ, 32'h60, 1'b1, 3'd0, 1'b0, 32'h66);
    step(); step(); step();
    lock[1] = 1'b0;
    step(); step();
    trans[0] = IDLE;
    step();

    // two-cycle ERROR on M1's data phase
    set_mgr(1, NONSEQ, 32'h70, 1'b0, 3'd0, 1'b0, 32'h0);
    step(); step();
    trans[1] = IDLE;
    s_ready = 1'b0; s_resp = 2'b01;
    step();
    s_ready = 1'b1;
    step();
    s_resp = 2'b00;
    step();

    rnd_mode = 1;
    repeat (3000) step();
    rnd_mode = 0;

    HRESET = 1'b0;
    for (int i = 0; i < N; i++) begin
      trans[i] = IDLE; lock[i] = 1'b0;
    end
    s_ready = 1'b1; s_resp = 2'b00;
    step(); step();
    @(negedge HCLK);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
